booth_mul_arbiter_ctrl: RTL
===========================

Name: booth_mul_arbiter_ctrl

Overview:
- Sequencer and 2-way round-robin arbiter for the shared radix-2 Booth multiplier datapath (A/Q/Q-1 registers, adder/subtractor, arithmetic shift).
- Accepts signed multiply requests from two requesters over valid/ready handshakes and grants one at a time.
- Drives the datapath control strobes for N add/sub + shift iterations.
- Returns the 2N-bit product tagged with the requester ID over a valid/ready response channel.

Parameters:
- N, 3, operand width in bits (two's complement). Must be ≥2.
- CW, $clog2(N+1), iteration counter width. Derived localparam; not overridable.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  2  bit i = requester i has an operation pending
- req_ready  out  2  bit i = request i accepted this cycle; one-hot or zero
- req_mcand  in  2N  {mcand1, mcand0} multiplicands
- req_mplier  in  2N  {mplier1, mplier0} multipliers
- dp_mcand  out  N  latched multiplicand to datapath
- dp_mplier  out  N  latched multiplier to datapath
- dp_load_qm  out  1  load Q←mplier, M←mcand, Q-1←0
- dp_clear_a  out  1  A←0
- dp_load_a  out  1  A←A±M
- dp_sub  out  1  select subtract for dp_load_a
- dp_shift_aq  out  1  arithmetic right shift of {A,Q,Q-1}
- dp_q0  in  1  datapath Q[0]
- dp_qm1  in  1  datapath Q-1
- dp_result  in  2N  datapath {A,Q}
- rsp_valid  out  1  product available
- rsp_id  out  1  requester that owns the product
- rsp_data  out  2N  signed product
- rsp_ready  in  1  consumer accepts response

Behaviour:
- Reset (async): state=IDLE; rr pointer favours requester 0; all outputs 0, including dp_mcand, dp_mplier, rsp_id, and the count.
- FSM states:
  - IDLE: if any req_valid, grant per round-robin. Assert req_ready[g] combinationally this cycle, register operands and id, go to LOAD. Otherwise stay in IDLE.
  - LOAD: dp_load_qm=1, dp_clear_a=1, count←N. Go to EVAL.
  - EVAL: dp_load_a = dp_q0 ^ dp_qm1; dp_sub = dp_q0 & ~dp_qm1. Go to SHIFT.
  - SHIFT: dp_shift_aq=1, count←count−1. If count==1 go to RESP, else go to EVAL.
  - RESP: rsp_valid=1, rsp_data=dp_result (combinational; no strobes asserted, so the datapath holds), rsp_id=latched id. On rsp_ready go to IDLE.
- All dp_* strobes are Moore outputs except dp_load_a and dp_sub, which are also gated by state EVAL. No strobe is asserted outside its state.
- Latency: accept at cycle T, rsp_valid at T+2N+2 (T+8 for N=3). Throughput is one op per 2N+3 cycles minimum; there is no bypass from RESP to grant.
- Round-robin: if both requesters are valid, grant the one not granted last. A single valid requester is always granted. The pointer updates only on grant.
- Backpressure: rsp_ready low holds RESP indefinitely with rsp_* stable. No new grant occurs in that time.
- Protocol: a requester holds req_valid and operands until its req_ready. req_ready is never asserted outside IDLE.
- dp_mcand/dp_mplier hold their value from grant until the next grant.
- Width rules: the product is the signed 2N-bit result. mcand = −2^(N−1) is supported; the datapath handles the A±M width.
- Reset mid-operation aborts immediately with no response. The pending requester is not acknowledged again; it re-requests.

Decomposition:
- Package booth_pkg holds:
  - state encoding IDLE=0, LOAD=1, EVAL=2, SHIFT=3, RESP=4 (3 bits);
  - default N;
  - the Booth decode constants (10=sub, 01=add).
- Sub-module rr_arbiter_2: 2-way round-robin with grant enable and pointer register. The top level holds the FSM, counter, and operand/id registers.

Test Plan:
- N=3, req0 mcand=3, mplier=2, rsp_ready=1 → req_ready=01 at T. EVAL strobes: none / sub / add. rsp at T+8, data=6 (000110), id=0.
- req1 mcand=−3 (101), mplier=3 (011) → rsp data=−9 (110111), id=1.
- Both valid at once for 3 back-to-back ops each → grants alternate 0,1,0,1,0,1. Each response id matches its grant.
- Hold rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_data, and rsp_id stay stable; req_ready stays 0; no dp strobes.
- Assert reset during the second SHIFT → all outputs 0 asynchronously. Next request completes normally and is granted to requester 0.
- mcand=−4 (100), mplier=−4 → product 16 (010000). Exhaustive sweep of all 64 operand pairs matches the signed reference product.

Source files
------------

// File: rtl/booth_mul_arbiter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : booth_pkg
// Brief   : Shared state encoding and Booth decode constants for the
//           round-robin Booth multiplier sequencer.
// Rev     : 1.0 - initial release
// ============================================================================
package booth_pkg;

   localparam int c_n_default = 3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_EVAL  = 3'd2,
      ST_SHIFT = 3'd3,
      ST_RESP  = 3'd4
   } state_t;

   // {Q[0], Q-1} pairs that trigger an A update
   localparam logic [1:0] c_booth_sub = 2'b10;
   localparam logic [1:0] c_booth_add = 2'b01;

endpackage
`default_nettype wire

// File: rtl/booth_mul_arbiter_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : booth_mul_arbiter_ctrl_if
// Brief     : Request, datapath-control and response signals of the Booth
//             multiplier sequencer; master = controller side.
// Rev       : 1.0 - initial release
// ============================================================================
interface booth_mul_arbiter_ctrl_if import booth_pkg::*; #(
   parameter int N = c_n_default
) ();

   logic [1:0]     req_valid;
   logic [1:0]     req_ready;
   logic [2*N-1:0] req_mcand;
   logic [2*N-1:0] req_mplier;

   logic [N-1:0]   dp_mcand;
   logic [N-1:0]   dp_mplier;
   logic           dp_load_qm;
   logic           dp_clear_a;
   logic           dp_load_a;
   logic           dp_sub;
   logic           dp_shift_aq;
   logic           dp_q0;
   logic           dp_qm1;
   logic [2*N-1:0] dp_result;

   logic           rsp_valid;
   logic           rsp_id;
   logic [2*N-1:0] rsp_data;
   logic           rsp_ready;

   modport master (
      input  req_valid, req_mcand, req_mplier, dp_q0, dp_qm1, dp_result, rsp_ready,
      output req_ready, dp_mcand, dp_mplier, dp_load_qm, dp_clear_a, dp_load_a,
             dp_sub, dp_shift_aq, rsp_valid, rsp_id, rsp_data
   );

   modport slave (
      output req_valid, req_mcand, req_mplier, dp_q0, dp_qm1, dp_result, rsp_ready,
      input  req_ready, dp_mcand, dp_mplier, dp_load_qm, dp_clear_a, dp_load_a,
             dp_sub, dp_shift_aq, rsp_valid, rsp_id, rsp_data
   );

endinterface
`default_nettype wire

// File: rtl/booth_mul_arbiter_ctrl_rr_arbiter_2.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter_2
// Brief  : Two-way round-robin arbiter; pointer advances only on enabled grant.
// Rev    : 1.0 - initial release
// ============================================================================
module rr_arbiter_2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] i_req,
   input  logic       i_en,
   output logic [1:0] o_grant
);

   // Remembers the last winner; resets to 1 so requester 0 wins the first tie
   logic r_last;

   always_comb begin
      o_grant = i_req;
      if (i_req == 2'b11) begin
         o_grant = r_last ? 2'b01 : 2'b10;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_last <= 1'b1;
      end else if (i_en && (o_grant != 2'b00)) begin
         r_last <= o_grant[1];
      end
   end

endmodule
`default_nettype wire

// File: rtl/booth_mul_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module : booth_mul_arbiter_ctrl
// Brief  : Arbitrates two signed multiply requesters onto one radix-2 Booth
//          datapath and sequences its load/add/sub/shift strobes.
// Rev    : 1.0 - initial release
// ============================================================================
module booth_mul_arbiter_ctrl import booth_pkg::*; #(
   parameter int N = c_n_default
) (
   input  logic                      clk,
   input  logic                      reset,
   booth_mul_arbiter_ctrl_if.master  bus
);

   localparam int CW = $clog2(N + 1);

   state_t         r_state;
   state_t         w_next;
   logic [1:0]     w_grant;
   logic           w_grant_en;
   logic [1:0]     w_booth;
   logic [N-1:0]   r_mcand;
   logic [N-1:0]   r_mplier;
   logic           r_id;
   logic [CW-1:0]  r_count;

   assign w_grant_en = (r_state == ST_IDLE);
   assign w_booth    = {bus.dp_q0, bus.dp_qm1};

   rr_arbiter_2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .i_req   (bus.req_valid),
      .i_en    (w_grant_en),
      .o_grant (w_grant)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Operands and id stay latched until the next grant
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_id     <= 1'b0;
         r_count  <= '0;
      end else begin
         if (w_grant_en && (w_grant != 2'b00)) begin
            r_id     <= w_grant[1];
            r_mcand  <= w_grant[1] ? bus.req_mcand[2*N-1:N]  : bus.req_mcand[N-1:0];
            r_mplier <= w_grant[1] ? bus.req_mplier[2*N-1:N] : bus.req_mplier[N-1:0];
         end
         if (r_state == ST_LOAD) begin
            r_count <= CW'(N);
         end else if (r_state == ST_SHIFT) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

   always_comb begin
      w_next          = r_state;
      bus.req_ready   = 2'b00;
      bus.dp_load_qm  = 1'b0;
      bus.dp_clear_a  = 1'b0;
      bus.dp_load_a   = 1'b0;
      bus.dp_sub      = 1'b0;
      bus.dp_shift_aq = 1'b0;
      bus.rsp_valid   = 1'b0;
      bus.rsp_data    = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_grant != 2'b00) begin
               bus.req_ready = w_grant;
               w_next        = ST_LOAD;
            end
         end
         ST_LOAD: begin
            bus.dp_load_qm = 1'b1;
            bus.dp_clear_a = 1'b1;
            w_next         = ST_EVAL;
         end
         ST_EVAL: begin
            bus.dp_load_a = (w_booth == c_booth_add) || (w_booth == c_booth_sub);
            bus.dp_sub    = (w_booth == c_booth_sub);
            w_next        = ST_SHIFT;
         end
         ST_SHIFT: begin
            bus.dp_shift_aq = 1'b1;
            w_next          = (r_count == CW'(1)) ? ST_RESP : ST_EVAL;
         end
         ST_RESP: begin
            // Product read straight from the datapath, which holds while idle
            bus.rsp_valid = 1'b1;
            bus.rsp_data  = bus.dp_result;
            if (bus.rsp_ready) begin
               w_next = ST_IDLE;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   assign bus.dp_mcand  = r_mcand;
   assign bus.dp_mplier = r_mplier;
   assign bus.rsp_id    = r_id;

endmodule
`default_nettype wire
